// File: rtl/pipe_reg_chain.sv
// WIDTH x DEPTH pipeline register chain with per-stage valid bits, ready/valid
// backpressure, bubble collapsing and synchronous flush. Define PIPE_REG_CHAIN_OCC_EN for an occupancy count.
module pipe_reg_chain #(
  parameter int               WIDTH     = 32,
  parameter int               DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
`ifdef PIPE_REG_CHAIN_OCC_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
`endif
);

  // Handshakes: a transfer happens on a posedge where valid && ready; valid must not
  // depend on ready, and an offered item is held by its source until it transfers.
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;
  logic [DEPTH-1:0] adv;
  logic [DEPTH-1:0] accept;
  logic [DEPTH-1:0] load;

  always_comb begin
    adv     = '0;
    accept  = '0;
    load    = '0;
    valid_d = valid_q;
    data_d  = data_q;

    // Stage i can move on if any stage downstream of it is empty or the sink is taking data.
    for (int i = 0; i < DEPTH; i++) begin
      adv[i] = out_ready;
      for (int j = i + 1; j < DEPTH; j++) begin
        if (!valid_q[j]) adv[i] = 1'b1;
      end
    end
    accept = ~valid_q | adv;

    in_ready  = accept[0] && !flush;
    out_valid = valid_q[DEPTH-1] && !flush;

    load[0] = in_valid && in_ready;
    for (int i = 1; i < DEPTH; i++) begin
      load[i] = valid_q[i-1] && accept[i] && !flush;
    end

    for (int i = 0; i < DEPTH; i++) begin
      if (flush)                       valid_d[i] = 1'b0;
      else if (load[i])                valid_d[i] = 1'b1;
      else if (valid_q[i] && adv[i])   valid_d[i] = 1'b0;
    end

    // Data registers only change on a load; invalid stages keep their stale contents.
    if (load[0]) data_d[0] = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      if (load[i]) data_d[i] = data_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) data_q[i] <= RESET_VAL;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_data = data_q[DEPTH-1];

`ifdef PIPE_REG_CHAIN_OCC_EN
  localparam int OW = $clog2(DEPTH+1);
  logic [OW-1:0] occ_q;
  logic [OW-1:0] occ_d;

  always_comb begin
    occ_d = occ_q;
    if (flush) occ_d = '0;
    else       occ_d = occ_q + OW'(in_valid && in_ready) - OW'(out_valid && out_ready);
  end

  always_ff @(posedge clk) begin
    if (rst) occ_q <= '0;
    else     occ_q <= occ_d;
  end

  assign occupancy = occ_q;
`endif

endmodule

// File: doc/pipe_reg_chain.md
Name: pipe_reg_chain

Overview:
- Parametrised, multi-stage pipeline register chain for KGP-miniRISC datapath staging (e.g. IF/ID, ID/EX boundaries).
- Generalises the single-bit synchronous-reset flop to WIDTH bits × DEPTH stages.
- Adds per-stage valid bits, ready/valid backpressure with bubble collapsing, and a synchronous flush for branch/jump squash.

Parameters:
- WIDTH, 32, data bits per stage; ≥1.
- DEPTH, 2, number of register stages; ≥1.
- RESET_VAL, 0, value loaded into every stage data register on reset; WIDTH bits.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous squash of all in-flight entries.
- in_data  in  WIDTH  upstream data.
- in_valid  in  1  upstream data valid.
- in_ready  out  1  chain can accept in_data this cycle.
- out_data  out  WIDTH  data of last stage.
- out_valid  out  1  last stage holds a valid entry.
- out_ready  in  1  downstream accepts out_data this cycle.

Behaviour:
- State per stage i (0 = input side, DEPTH-1 = output side): data register d[i] (WIDTH bits) and valid bit v[i].
- Reset: when rst=1 at posedge, all v[i]=0 and all d[i]=RESET_VAL.
  - After reset, out_valid=0 and out_data=RESET_VAL.
  - in_ready is driven combinationally; it is 1 after reset unless flush=1.
  - rst has priority over flush and all transfers.
  - rst asserted mid-operation discards every in-flight entry.
- Advance (combinational):
  - adv[DEPTH-1] = out_ready.
  - For i<DEPTH-1: adv[i] = !v[i+1] || adv[i+1].
  - Stage i accepts new data when !v[i] || adv[i].
- in_ready = (!v[0] || adv[0]) && !flush.
- Transfers:
  - Input handshake: in_valid && in_ready.
  - Output handshake: out_valid && out_ready.
- Per-stage update (rst=0, flush=0):
  - Stage 0 loads in_data when in_valid && in_ready.
  - Stage i>0 loads d[i-1] when v[i-1] && stage i accepts.
  - v[i] next = 1 if loaded this cycle.
  - v[i] next = 0 if v[i] and its entry left this cycle without replacement.
  - Otherwise v[i] holds.
  - d[i] changes only on a load; otherwise it holds, including when v[i]=0.
- Bubble collapsing: an invalid stage always accepts, so bubbles are squeezed out even when out_ready=0.
- Flush (rst=0, flush=1): all v[i] next = 0.
  - d[i] is unchanged.
  - in_ready=0 and out_valid=0 during the flush cycle, so no transfer occurs.
  - Flush and in_valid in the same cycle: input is not accepted; upstream must hold or drop it.
- out_valid = v[DEPTH-1] && !flush; out_data = d[DEPTH-1].
- Latency: into an empty chain with out_ready=1, an item accepted at edge T gives out_valid=1 after edge T+DEPTH-1. That is, DEPTH cycles from in_valid assertion to out_valid.
- Throughput: 1 item/cycle sustained when out_ready=1.
- Full chain (all v=1) with out_ready=0: in_ready=0 and all state holds.
- Full chain with out_ready=1: simultaneous in and out transfer; occupancy stays at DEPTH.
- Ordering: items exit in acceptance order; none duplicated or lost except by flush or rst.
- DEPTH=1 degenerates to a single register with in_ready = !v[0] || out_ready.

Optional Feature:
- Macro PIPE_REG_CHAIN_OCC_EN.
- Defined:
  - Adds output port occupancy (width $clog2(DEPTH+1)), registered, equal to the count of set v[i] after each edge.
  - Reset value is 0; cleared to 0 by flush.
  - Increments/decrements by the net of input and output transfers; never exceeds DEPTH.
- Undefined: port and counter are absent; behaviour otherwise identical.

Test Plan:
- Reset, WIDTH=32, DEPTH=3, RESET_VAL=32'hDEAD_BEEF: after rst for 2 cycles → out_valid=0, out_data=32'hDEADBEEF, in_ready=1 (occupancy=0 if enabled).
- Streaming, out_ready=1, in_valid=1 with data 1,2,3,4,5 on consecutive cycles → out_valid rises 3 cycles after first in_valid; out_data=1..5 on consecutive cycles; no gaps.
- Backpressure: fill with 10,11,12, hold out_ready=0 → in_ready=0 and out_data=10 stable. Release out_ready for 1 cycle → 10 exits, in_ready=1; next accepted item 13 lands behind 12.
- Bubble collapse: send 7, idle 2 cycles, send 8, all with out_ready=0 → both 7 and 8 are resident, in_ready=1, occupancy=2. Then out_ready=1 → out 7 then 8 on consecutive cycles.
- Flush mid-stream: chain holds 20,21,22; assert flush with in_valid=1 and in_data=23 → that cycle out_valid=0 and in_ready=0; next cycle all valid=0, 23 not captured, occupancy=0.
- rst during backpressured full chain → next cycle out_valid=0, out_data=RESET_VAL, in_ready=1; subsequent item 30 emerges after DEPTH cycles.
